debug_unit: RTL and testbench

- Host-side control end of the MIPS pipeline.
- Receives a program and commands as bytes from the UART receiver, and writes the program into instruction memory.
- Starts the pipeline in continuous or single-step mode by gating its clock enable and pulsing its reset.
- Streams PC, cycle count and the register file back to the host byte by byte through the UART transmitter.

---
 rtl/debug_unit.sv | 184 ++++++++++++++++++
 tb/tb_debug_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host-side debug controller for the MIPS pipeline: loads instruction memory from UART
// bytes, runs or single-steps the pipeline, and streams PC/cycle count/register file back.
module debug_unit #(
    parameter int LEN        = 32,
    parameter int NB         = $clog2(LEN),
    parameter int ADDR_W     = 8,
    parameter int MAX_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] out_imem_addr,
    output logic [LEN-1:0]    out_imem_data,
    output logic              out_imem_wr,
    output logic              out_pipe_enable,
    output logic              out_pipe_reset,
    input  logic [LEN-1:0]    in_pc,
    input  logic              in_halt,
    output logic [NB-1:0]     out_reg_addr,
    input  logic [LEN-1:0]    in_reg_data
);
    localparam int FRAME_BYTES = 8 + 4 * (2 ** NB);
    localparam int IDX_W       = $clog2(FRAME_BYTES);

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_WR, RUN, STEP_WAIT, STEP_EXEC, DUMP_SEND, DUMP_WAIT
    } state_t;

    state_t             state_q, ret_q;
    logic [LEN-1:0]     word_q, cnt_q, pc_cap_q;
    logic [1:0]         byte_cnt_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q, imem_wr_q, pipe_reset_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic [LEN-1:0]     imem_data_q;

    logic [LEN-1:0]     word_d, cnt_d, frame_word;
    logic [IDX_W-1:0]   reg_off;
    logic [7:0]         frame_byte;

    assign word_d  = {word_q[LEN-9:0], rx_data};
    assign cnt_d   = cnt_q + 1'b1;
    assign reg_off = idx_q - IDX_W'(8);

    // Enable is combinational so a halt stops the pipeline in the very cycle it is seen;
    // the first RUN cycle carries the reset pulse and must not enable.
    assign out_pipe_enable = !in_halt &&
        ((state_q == RUN && !pipe_reset_q) || state_q == STEP_EXEC);

    assign out_reg_addr = (idx_q >= IDX_W'(8)) ? NB'(reg_off >> 2) : '0;

    always_comb begin
        frame_word = in_reg_data;
        if (idx_q == '0)
            frame_word = in_pc;
        else if (idx_q < IDX_W'(4))
            frame_word = pc_cap_q;
        else if (idx_q < IDX_W'(8))
            frame_word = cnt_q;
        case (idx_q[1:0])
            2'd0:    frame_byte = frame_word[31:24];
            2'd1:    frame_byte = frame_word[23:16];
            2'd2:    frame_byte = frame_word[15:8];
            default: frame_byte = frame_word[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            word_q       <= '0;
            cnt_q        <= '0;
            pc_cap_q     <= '0;
            byte_cnt_q   <= '0;
            ptr_q        <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            imem_wr_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_data_q  <= '0;
            pipe_reset_q <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            imem_wr_q    <= 1'b0;
            pipe_reset_q <= 1'b0;
            case (state_q)
                IDLE: if (rx_done) begin
                    case (rx_data)
                        8'h4C: begin
                            ptr_q      <= '0;
                            byte_cnt_q <= '0;
                            state_q    <= LOAD;
                        end
                        8'h43: begin
                            pipe_reset_q <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= RUN;
                        end
                        8'h53: begin
                            pipe_reset_q <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= STEP_WAIT;
                        end
                        default: ;
                    endcase
                end
                LOAD: if (rx_done) begin
                    word_q     <= word_d;
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_data_q <= word_d;
                        imem_addr_q <= ptr_q;
                        imem_wr_q   <= 1'b1;
                        state_q     <= LOAD_WR;
                    end
                end
                LOAD_WR: begin
                    ptr_q   <= ptr_q + 1'b1;
                    state_q <= (&imem_data_q) ? IDLE : LOAD;
                end
                RUN: if (!pipe_reset_q) begin
                    if (in_halt) begin
                        idx_q   <= '0;
                        ret_q   <= IDLE;
                        state_q <= DUMP_SEND;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_q == LEN'(MAX_CYCLES - 1)) begin
                            idx_q   <= '0;
                            ret_q   <= IDLE;
                            state_q <= DUMP_SEND;
                        end
                    end
                end
                STEP_WAIT: if (rx_done) begin
                    if (rx_data == 8'h4E)
                        state_q <= STEP_EXEC;
                    else if (rx_data == 8'h45)
                        state_q <= IDLE;
                end
                STEP_EXEC: begin
                    if (!in_halt)
                        cnt_q <= cnt_d;
                    idx_q   <= '0;
                    ret_q   <= STEP_WAIT;
                    state_q <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    // PC is frozen for the rest of the frame from its first byte on.
                    if (idx_q == '0)
                        pc_cap_q <= in_pc;
                    tx_data_q  <= frame_byte;
                    tx_start_q <= 1'b1;
                    state_q    <= DUMP_WAIT;
                end
                DUMP_WAIT: if (tx_done) begin
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        idx_q   <= '0;
                        state_q <= ret_q;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= DUMP_SEND;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data        = tx_data_q;
    assign tx_start       = tx_start_q;
    assign out_imem_addr  = imem_addr_q;
    assign out_imem_data  = imem_data_q;
    assign out_imem_wr    = imem_wr_q;
    assign out_pipe_reset = pipe_reset_q;
endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: scoreboards for imem writes and dump bytes, plus a
// small pipeline model (PC, halt, register file) on the DUT's debug inputs.
module tb_debug_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  out_imem_addr;
    logic [31:0] out_imem_data;
    logic        out_imem_wr;
    logic        out_pipe_enable;
    logic        out_pipe_reset;
    logic [31:0] in_pc;
    logic        in_halt;
    logic [4:0]  out_reg_addr;
    logic [31:0] in_reg_data;

    debug_unit dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .out_imem_addr(out_imem_addr), .out_imem_data(out_imem_data),
        .out_imem_wr(out_imem_wr), .out_pipe_enable(out_pipe_enable),
        .out_pipe_reset(out_pipe_reset), .in_pc(in_pc), .in_halt(in_halt),
        .out_reg_addr(out_reg_addr), .in_reg_data(in_reg_data)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int tx_cnt = 0, wr_cnt = 0, en_cnt = 0, prst_cnt = 0, overlap = 0;
    int tx_target = 0;
    logic [7:0]  tx_sb[$];
    logic [39:0] wr_sb[$];
    logic [31:0] regs_m[32];
    logic [31:0] pipe_cyc;
    logic        halt_en;
    logic [31:0] halt_at;

    // Pipeline model: cycle counter advances per enabled edge, PC = 4 * cycles.
    always @(posedge clk) begin
        if (reset || out_pipe_reset)
            pipe_cyc <= '0;
        else if (out_pipe_enable)
            pipe_cyc <= pipe_cyc + 1;
    end
    assign in_pc       = pipe_cyc << 2;
    assign in_halt     = halt_en && (pipe_cyc >= halt_at);
    assign in_reg_data = regs_m[out_reg_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (out_pipe_enable) en_cnt++;
        if (out_pipe_reset) prst_cnt++;
        if (out_pipe_enable && out_pipe_reset) overlap++;
        if (out_imem_wr) begin
            wr_cnt++;
            check("imem_wr_expected", 64'(wr_sb.size() > 0), 64'd1);
            if (wr_sb.size() > 0) check("imem_write", {out_imem_addr, out_imem_data}, wr_sb.pop_front());
        end
        if (tx_start) begin
            tx_cnt++;
            check("tx_expected", 64'(tx_sb.size() > 0), 64'd1);
            if (tx_sb.size() > 0) check("dump_byte", tx_data, tx_sb.pop_front());
        end
    end

    // UART transmitter model: finishes each byte a couple of cycles after tx_start.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (2) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    endtask

    task automatic push_frame(input logic [31:0] pc, input logic [31:0] cyc);
        logic [31:0] w;
        for (int i = 0; i < 136; i++) begin
            w = (i < 4) ? pc : (i < 8) ? cyc : regs_m[(i - 8) / 4];
            tx_sb.push_back(w[8*(3 - i % 4) +: 8]);
        end
        tx_target = tx_cnt + 136;
    endtask

    task automatic wait_frame(input int budget);
        int c = 0;
        while (tx_cnt < tx_target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("frame_len", tx_cnt, tx_target);
        repeat (8) @(posedge clk);
        check("frame_drained", tx_sb.size(), 0);
    endtask

    initial begin
        int c;
        int base;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'h9E37_79B9 * (i + 1) ^ {24'h0, 8'(i)};
        reset = 1'b1; rx_data = '0; rx_done = 1'b0; halt_en = 1'b0; halt_at = '0;

        // 1: reset state, three-word load, 'N' ignored in IDLE
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_imem_wr", out_imem_wr, 0);
        check("rst_imem_addr", out_imem_addr, 0);
        check("rst_imem_data", out_imem_data, 0);
        check("rst_enable", out_pipe_enable, 0);
        check("rst_pipe_reset", out_pipe_reset, 0);
        check("rst_reg_addr", out_reg_addr, 0);
        @(posedge clk); #1 reset = 1'b0;
        wr_sb.push_back({8'd0, 32'h2001_0005});
        wr_sb.push_back({8'd1, 32'h0000_0000});
        wr_sb.push_back({8'd2, 32'hFFFF_FFFF});
        send_byte(8'h4C);
        send_word(32'h2001_0005); send_word(32'h0); send_word(32'hFFFF_FFFF);
        send_byte(8'h4E);
        repeat (10) @(posedge clk);
        check("load_writes", wr_cnt, 3);
        check("idle_no_enable", en_cnt, 0);
        check("idle_no_tx", tx_cnt, 0);

        // 2: continuous run halting after 7 enabled cycles
        halt_en = 1'b1; halt_at = 7; en_cnt = 0; prst_cnt = 0;
        push_frame(32'd28, 32'd7);
        send_byte(8'h43);
        wait_frame(3000);
        check("run_enables", en_cnt, 7);
        check("run_pipe_reset", prst_cnt, 1);

        // 3: single-step three times, exit, then 'C' accepted
        halt_en = 1'b0; en_cnt = 0; prst_cnt = 0;
        send_byte(8'h53);
        check("step_pipe_reset", prst_cnt, 1);
        for (int k = 1; k <= 3; k++) begin
            push_frame(32'(4 * k), 32'(k));
            send_byte(8'h4E);
            wait_frame(3000);
            check("step_enables", en_cnt, k);
        end
        send_byte(8'h45);
        halt_en = 1'b1; halt_at = 2;
        push_frame(32'd8, 32'd2);
        send_byte(8'h43);
        wait_frame(3000);
        check("post_step_run_enables", en_cnt, 5);

        // 4: watchdog stops a run with no halt
        halt_en = 1'b0; en_cnt = 0;
        push_frame(32'h1000, 32'h400);
        send_byte(8'h43);
        wait_frame(5000);
        check("watchdog_enables", en_cnt, 1024);

        // 5: reset in the middle of a dump
        halt_en = 1'b1; halt_at = 3; wr_cnt = 0;
        push_frame(32'd12, 32'd3);
        base = tx_cnt;
        send_byte(8'h43);
        c = 0;
        while (tx_cnt < base + 50 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("reach_byte50", tx_cnt, base + 50);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_enable", out_pipe_enable, 0);
        check("midrst_reg_addr", out_reg_addr, 0);
        @(posedge clk); #1 reset = 1'b0;
        tx_sb.delete();
        repeat (40) @(posedge clk);
        check("no_tx_after_reset", tx_cnt, base + 50);
        wr_sb.push_back({8'd0, 32'h0BAD_F00D});
        wr_sb.push_back({8'd1, 32'hFFFF_FFFF});
        send_byte(8'h4C);
        send_word(32'h0BAD_F00D); send_word(32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        check("reload_writes", wr_cnt, 2);

        // 6: load pointer wraps past 255; bytes during a dump are dropped
        wr_cnt = 0;
        send_byte(8'h4C);
        for (int i = 0; i < 255; i++) begin
            wr_sb.push_back({8'(i), 8'hC0, 8'(i), 8'h5A, 8'(i)});
            send_word({8'hC0, 8'(i), 8'h5A, 8'(i)});
        end
        wr_sb.push_back({8'd255, 32'hDEAD_BEEF});
        wr_sb.push_back({8'd0, 32'hFFFF_FFFF});
        send_word(32'hDEAD_BEEF); send_word(32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        check("wrap_writes", wr_cnt, 257);
        halt_en = 1'b0; en_cnt = 0;
        send_byte(8'h53);
        push_frame(32'd4, 32'd1);
        send_byte(8'h4E);
        send_byte(8'h4C); send_byte(8'h12); send_byte(8'h43); send_byte(8'h45);
        wait_frame(3000);
        check("dump_rx_no_write", wr_cnt, 257);
        push_frame(32'd8, 32'd2);
        send_byte(8'h4E);
        wait_frame(3000);
        check("dump_rx_state_kept", en_cnt, 2);

        check("enable_reset_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
